// File: rtl/heartaware_pkg.sv
// Shared definitions for the heart-aware signal capture path.
// Holds the sampler state encoding and the sample memory geometry.
package heartaware_pkg;

    localparam int SAMPLE_W   = 8;
    localparam int SIG_ADDR_W = 10;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t WR_PULSE  = 3'd1;
    localparam state_t WAIT_INTR = 3'd2;
    localparam state_t RD_ACCESS = 3'd3;
    localparam state_t WRITE     = 3'd4;

endpackage

// File: rtl/sample_tick_gen.sv
// Enable-gated sample period counter.
// Emits a registered one-cycle tick each time the count wraps; holds at zero while disabled.
module sample_tick_gen #(
    parameter int PERIOD = 100_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (!enable) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == CW'(PERIOD - 1)) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + CW'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/synchronize.sv
// Two-flop synchronizer for a single asynchronous level.
// RESET_VAL lets active-low inputs come out of reset in their inactive state.
module synchronize #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc0804_sampler.sv
// ADC0804 bus initiator: periodically starts a conversion, waits for INTR_n,
// reads the byte and writes it into the signal memory at a wrapping address.
module adc0804_sampler
    import heartaware_pkg::*;
#(
    parameter int SAMPLE_PERIOD  = 100_000,
    parameter int WR_LOW_CYCLES  = 20,
    parameter int RD_CYCLES      = 30,
    parameter int TIMEOUT_CYCLES = 20_000,
    parameter int ADDR_W         = SIG_ADDR_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                clear_err,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_intr_n,
    output logic                adc_cs_n,
    output logic                adc_rd_n,
    output logic                adc_wr_n,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [SAMPLE_W-1:0] mem_din,
    output logic                busy,
    output logic                timeout_err,
    output logic                overrun_err
);

    localparam int MAX_A   = (WR_LOW_CYCLES > RD_CYCLES) ? WR_LOW_CYCLES : RD_CYCLES;
    localparam int CNT_MAX = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             rst_sync_n;
    logic             intr_sync;
    logic             tick;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
    logic             overrun_hit;

    // Reset asserts immediately but releases on a clock edge.
    synchronize #(.RESET_VAL(1'b0)) u_rst_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (1'b1),
        .q       (rst_sync_n)
    );

    synchronize #(.RESET_VAL(1'b1)) u_intr_sync (
        .clk     (clk),
        .reset_n (rst_sync_n),
        .d       (adc_intr_n),
        .q       (intr_sync)
    );

    sample_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick_gen (
        .clk     (clk),
        .reset_n (rst_sync_n),
        .enable  (enable),
        .tick    (tick)
    );

    assign busy        = (state != IDLE);
    assign timeout_hit = (state == WAIT_INTR) && intr_sync && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign overrun_hit = tick && busy;

    // One shared phase counter times the WR pulse, the INTR wait and the RD window.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state    <= IDLE;
            cnt      <= '0;
            adc_cs_n <= 1'b1;
            adc_rd_n <= 1'b1;
            adc_wr_n <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        state    <= WR_PULSE;
                        cnt      <= '0;
                        adc_cs_n <= 1'b0;
                        adc_wr_n <= 1'b0;
                    end
                end
                WR_PULSE: begin
                    if (cnt == CNT_W'(WR_LOW_CYCLES - 1)) begin
                        state    <= WAIT_INTR;
                        cnt      <= '0;
                        adc_cs_n <= 1'b1;
                        adc_wr_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_INTR: begin
                    if (!intr_sync) begin
                        state    <= RD_ACCESS;
                        cnt      <= '0;
                        adc_cs_n <= 1'b0;
                        adc_rd_n <= 1'b0;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RD_ACCESS: begin
                    if (cnt == CNT_W'(RD_CYCLES - 1)) begin
                        state    <= WRITE;
                        cnt      <= '0;
                        adc_cs_n <= 1'b1;
                        adc_rd_n <= 1'b1;
                        mem_din  <= adc_data;
                        mem_we   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    state    <= IDLE;
                    mem_addr <= mem_addr + ADDR_W'(1);
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    adc_cs_n <= 1'b1;
                    adc_rd_n <= 1'b1;
                    adc_wr_n <= 1'b1;
                end
            endcase
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit | (timeout_err & ~clear_err);
            overrun_err <= overrun_hit | (overrun_err & ~clear_err);
        end
    end

endmodule

// File: tb/tb_adc0804_sampler.sv
// Self-checking bench: two sampler instances (period 100 and 20) driven by an
// ADC behavioural model and checked every cycle against a transaction-level model.
module tb_adc0804_sampler;

    localparam int WR_LOW = 4;
    localparam int RD_LEN = 6;
    localparam int TMO    = 50;

    logic       clk = 1'b0;
    logic       reset_n     [2];
    logic       enable      [2];
    logic       clear_err   [2];
    logic       adc_intr_n  [2] = '{1'b1, 1'b1};
    logic [7:0] adc_data    [2] = '{8'h5A, 8'h5A};
    logic       adc_cs_n    [2];
    logic       adc_rd_n    [2];
    logic       adc_wr_n    [2];
    logic       mem_we      [2];
    logic [9:0] mem_addr    [2];
    logic [7:0] mem_din     [2];
    logic       busy        [2];
    logic       timeout_err [2];
    logic       overrun_err [2];

    // Stimulus-side configuration of the ADC model
    logic no_intr    [2];
    logic data_mode  [2];
    int   intr_delay [2];

    // Transaction-level model state
    logic prev_wr [2];
    logic prev_rd [2];
    int   wr_run  [2];
    int   rd_run  [2];
    logic in_txn  [2];
    logic waiting [2];
    int   wait_cnt[2];
    logic exp_to  [2];
    int   exp_addr[2];
    logic armed   [2];
    int   dcnt    [2];
    int   conv_idx[2];

    int vectors;
    int miscompares;

    always #5 clk = ~clk;

    adc0804_sampler #(
        .SAMPLE_PERIOD(100), .WR_LOW_CYCLES(WR_LOW), .RD_CYCLES(RD_LEN),
        .TIMEOUT_CYCLES(TMO), .ADDR_W(10)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n[0]), .enable(enable[0]), .clear_err(clear_err[0]),
        .adc_data(adc_data[0]), .adc_intr_n(adc_intr_n[0]),
        .adc_cs_n(adc_cs_n[0]), .adc_rd_n(adc_rd_n[0]), .adc_wr_n(adc_wr_n[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
        .busy(busy[0]), .timeout_err(timeout_err[0]), .overrun_err(overrun_err[0])
    );

    adc0804_sampler #(
        .SAMPLE_PERIOD(20), .WR_LOW_CYCLES(WR_LOW), .RD_CYCLES(RD_LEN),
        .TIMEOUT_CYCLES(TMO), .ADDR_W(10)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n[1]), .enable(enable[1]), .clear_err(clear_err[1]),
        .adc_data(adc_data[1]), .adc_intr_n(adc_intr_n[1]),
        .adc_cs_n(adc_cs_n[1]), .adc_rd_n(adc_rd_n[1]), .adc_wr_n(adc_wr_n[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
        .busy(busy[1]), .timeout_err(timeout_err[1]), .overrun_err(overrun_err[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic waitWrite(input int g, input int budget, input string name);
        int n = 0;
        do begin
            applyStimulus(1);
            n++;
        end while (!mem_we[g] && n < budget);
        if (!mem_we[g]) checkOutput({name, "_no_write"}, 32'd0, 32'd1);
    endtask

    // which: 0 selects wr_n, 1 selects rd_n
    task automatic waitStrobe(input int g, input int which, input logic level, input int budget, input string name);
        int n = 0;
        while (((which == 0) ? adc_wr_n[g] : adc_rd_n[g]) !== level && n < budget) begin
            applyStimulus(1);
            n++;
        end
        if (((which == 0) ? adc_wr_n[g] : adc_rd_n[g]) !== level)
            checkOutput({name, "_no_edge"}, 32'd0, 32'd1);
    endtask

    task automatic countToWrFall(input int g, output int n);
        n = 0;
        do begin
            applyStimulus(1);
            n++;
        end while (adc_wr_n[g] && n < 400);
    endtask

    // Compare process plus ADC behaviour, evaluated once per cycle away from the active edge.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            logic fall_wr, rise_wr, fall_rd, rise_rd, timeout_event;
            if (!reset_n[g]) begin
                checkOutput($sformatf("rst%0d_strobes", g), {adc_cs_n[g], adc_rd_n[g], adc_wr_n[g]}, 32'h7);
                checkOutput($sformatf("rst%0d_flags", g), {mem_we[g], busy[g], timeout_err[g], overrun_err[g]}, 32'h0);
                checkOutput($sformatf("rst%0d_addr", g), mem_addr[g], 32'h0);
                checkOutput($sformatf("rst%0d_din", g), mem_din[g], 32'h0);
                prev_wr[g] = 1'b1; prev_rd[g] = 1'b1;
                wr_run[g] = 0; rd_run[g] = 0;
                in_txn[g] = 1'b0; waiting[g] = 1'b0; wait_cnt[g] = 0;
                exp_to[g] = 1'b0; exp_addr[g] = 0;
                armed[g] = 1'b0; dcnt[g] = 0; conv_idx[g] = 0;
                adc_intr_n[g] = 1'b1;
            end else begin
                fall_wr = prev_wr[g] && !adc_wr_n[g];
                rise_wr = !prev_wr[g] && adc_wr_n[g];
                fall_rd = prev_rd[g] && !adc_rd_n[g];
                rise_rd = !prev_rd[g] && adc_rd_n[g];
                timeout_event = 1'b0;

                if (fall_wr) begin in_txn[g] = 1'b1; wr_run[g] = 0; end
                if (!adc_wr_n[g]) wr_run[g]++;
                if (rise_wr) begin
                    checkOutput($sformatf("wr%0d_low_len", g), wr_run[g], WR_LOW);
                    waiting[g] = 1'b1;
                    wait_cnt[g] = 0;
                end
                if (fall_rd) begin waiting[g] = 1'b0; rd_run[g] = 0; end
                if (!adc_rd_n[g]) rd_run[g]++;
                if (rise_rd) checkOutput($sformatf("rd%0d_low_len", g), rd_run[g], RD_LEN);
                if (waiting[g]) begin
                    wait_cnt[g]++;
                    if (wait_cnt[g] == TMO + 1) begin
                        waiting[g] = 1'b0;
                        in_txn[g] = 1'b0;
                        exp_to[g] = 1'b1;
                        timeout_event = 1'b1;
                    end
                end
                if (!timeout_event && clear_err[g]) exp_to[g] = 1'b0;

                checkOutput($sformatf("cs%0d_n", g), adc_cs_n[g], adc_rd_n[g] & adc_wr_n[g]);
                checkOutput($sformatf("rdwr%0d_overlap", g), !adc_rd_n[g] && !adc_wr_n[g], 32'd0);
                checkOutput($sformatf("busy%0d", g), busy[g], in_txn[g]);
                checkOutput($sformatf("mem_we%0d", g), mem_we[g], rise_rd);
                checkOutput($sformatf("timeout_err%0d", g), timeout_err[g], exp_to[g]);
                checkOutput($sformatf("mem_addr%0d", g), mem_addr[g], exp_addr[g]);
                if (mem_we[g]) begin
                    checkOutput($sformatf("mem_din%0d", g), mem_din[g], adc_data[g]);
                    exp_addr[g] = (exp_addr[g] + 1) % 1024;
                    in_txn[g] = 1'b0;
                end

                // ADC: new data at conversion start, INTR_n low after a delay, released by RD_n
                if (rise_wr) begin
                    if (!no_intr[g]) begin armed[g] = 1'b1; dcnt[g] = 0; end
                    adc_data[g] = data_mode[g] ? 8'(conv_idx[g]) : 8'h5A;
                    conv_idx[g]++;
                end
                if (armed[g]) begin
                    dcnt[g]++;
                    if (dcnt[g] >= intr_delay[g]) begin
                        adc_intr_n[g] = 1'b0;
                        armed[g] = 1'b0;
                    end
                end
                if (fall_rd) adc_intr_n[g] = 1'b1;

                prev_wr[g] = adc_wr_n[g];
                prev_rd[g] = adc_rd_n[g];
            end
        end
    end

    initial begin
        int n;
        int writes;
        logic last_wr;
        vectors = 0;
        miscompares = 0;
        for (int g = 0; g < 2; g++) begin
            reset_n[g] = 1'b0;
            enable[g] = 1'b0;
            clear_err[g] = 1'b0;
            no_intr[g] = 1'b0;
            data_mode[g] = 1'b0;
            intr_delay[g] = 20;
        end
        applyStimulus(3);
        checkOutput("reset_wr_n", adc_wr_n[0], 32'd1);
        checkOutput("reset_addr", mem_addr[0], 32'd0);

        $display("[TB] basic sampling");
        reset_n[0] = 1'b1;
        applyStimulus(5);
        enable[0] = 1'b1;
        countToWrFall(0, n);
        checkOutput("first_wr_latency", n, 32'd101);
        waitWrite(0, 300, "t1_w0");
        checkOutput("t1_addr0", mem_addr[0], 32'd0);
        checkOutput("t1_din0", mem_din[0], 32'h5A);
        waitWrite(0, 300, "t1_w1");
        checkOutput("t1_addr1", mem_addr[0], 32'd1);
        checkOutput("t1_no_overrun", overrun_err[0], 32'd0);

        $display("[TB] conversion timeout");
        no_intr[0] = 1'b1;
        waitStrobe(0, 0, 1'b0, 300, "t2_wr_fall");
        waitStrobe(0, 0, 1'b1, 20, "t2_wr_rise");
        applyStimulus(49);
        checkOutput("t2_to_before", timeout_err[0], 32'd0);
        applyStimulus(1);
        checkOutput("t2_to_at_50", timeout_err[0], 32'd1);
        checkOutput("t2_idle_after_to", busy[0], 32'd0);
        no_intr[0] = 1'b0;
        waitWrite(0, 300, "t2_w2");
        checkOutput("t2_addr2", mem_addr[0], 32'd2);
        checkOutput("t2_din2", mem_din[0], 32'h5A);
        clear_err[0] = 1'b1;
        applyStimulus(1);
        clear_err[0] = 1'b0;
        checkOutput("t2_cleared", timeout_err[0], 32'd0);

        $display("[TB] reset during read");
        waitStrobe(0, 1, 1'b0, 300, "t5_rd_fall");
        reset_n[0] = 1'b0;
        #1;
        checkOutput("t5_strobes_released", {adc_cs_n[0], adc_rd_n[0], adc_wr_n[0]}, 32'h7);
        checkOutput("t5_no_we", mem_we[0], 32'd0);
        applyStimulus(3);
        reset_n[0] = 1'b1;
        applyStimulus(1);
        checkOutput("t5_addr_after_reset", mem_addr[0], 32'd0);
        waitWrite(0, 400, "t5_resume");
        checkOutput("t5_resume_addr", mem_addr[0], 32'd0);

        $display("[TB] enable drop during wait");
        waitStrobe(0, 0, 1'b0, 300, "t6_wr_fall");
        waitStrobe(0, 0, 1'b1, 20, "t6_wr_rise");
        applyStimulus(5);
        enable[0] = 1'b0;
        waitWrite(0, 100, "t6_finish");
        checkOutput("t6_addr", mem_addr[0], 32'd1);
        n = 0;
        last_wr = adc_wr_n[0];
        for (int i = 0; i < 500; i++) begin
            applyStimulus(1);
            if (last_wr && !adc_wr_n[0]) n++;
            last_wr = adc_wr_n[0];
        end
        checkOutput("t6_no_wr_while_disabled", n, 32'd0);
        enable[0] = 1'b1;
        countToWrFall(0, n);
        checkOutput("t6_reenable_latency", n, 32'd101);

        $display("[TB] address wrap");
        data_mode[1] = 1'b1;
        intr_delay[1] = 1;
        reset_n[1] = 1'b1;
        applyStimulus(5);
        enable[1] = 1'b1;
        for (int k = 0; k < 1025; k++) begin
            waitWrite(1, 60, "t3_write");
            if (k == 1023) begin
                checkOutput("t3_addr_1023", mem_addr[1], 32'd1023);
                checkOutput("t3_din_1023", mem_din[1], 32'hFF);
            end
            if (k == 1024) begin
                checkOutput("t3_addr_wrap", mem_addr[1], 32'd0);
                checkOutput("t3_din_wrap", mem_din[1], 32'h00);
            end
        end

        $display("[TB] overrun");
        enable[1] = 1'b0;
        reset_n[1] = 1'b0;
        applyStimulus(2);
        data_mode[1] = 1'b0;
        intr_delay[1] = 20;
        reset_n[1] = 1'b1;
        applyStimulus(5);
        checkOutput("t4_no_overrun_yet", overrun_err[1], 32'd0);
        enable[1] = 1'b1;
        writes = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1);
            if (mem_we[1]) writes++;
        end
        checkOutput("t4_overrun_set", overrun_err[1], 32'd1);
        checkOutput("t4_writes_continue", writes >= 5, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
